// File: rtl/inst_rom_resp_pkg.sv
// Shared types and constants for the instruction ROM responder: boot FSM states,
// the nop word returned on disabled or out-of-range fetches, and the tail-padding helper.
package inst_rom_resp_pkg;

   localparam int INST_BUS_W      = 32;
   localparam int INST_ADDR_BUS_W = 32;
   localparam int BYTE_W          = 8;

   localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   typedef enum logic {
      BOOT_LOAD = 1'b0,
      BOOT_RUN  = 1'b1
   } boot_state_e;

   typedef logic [1:0] byte_cnt_t;

   // Builds the word to store given the bytes already collected and the byte arriving now.
   // The image is big-endian, so a short final word keeps its bytes at the top and
   // zero-fills the low end; with three bytes already held this is simply the full word.
   function automatic logic [INST_BUS_W-1:0] padWord(
      input logic [23:0]       shiftVal,
      input logic [BYTE_W-1:0] newByte,
      input byte_cnt_t         cnt
   );
      logic [INST_BUS_W-1:0] word;
      word = ZERO_WORD;
      case (cnt)
         2'd0:    word = {newByte, 24'h000000};
         2'd1:    word = {shiftVal[7:0], newByte, 16'h0000};
         2'd2:    word = {shiftVal[15:0], newByte, 8'h00};
         default: word = {shiftVal, newByte};
      endcase
      return word;
   endfunction

endpackage

// File: rtl/inst_rom_resp_boot_word_asm.sv
// Byte-serial to word assembler for the boot stream: collects big-endian bytes and
// pulses a write strobe on every fourth byte, or early on the image's final byte.
module inst_rom_resp_boot_word_asm
   import inst_rom_resp_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  byteValid_i,
   input  logic [BYTE_W-1:0]     bootByte_i,
   input  logic                  bootLast_i,
   output logic [INST_BUS_W-1:0] word_o,
   output logic                  wordWe_o,
   output logic                  lastSeen_o
);

   logic [23:0] shift_q, shift_d;
   byte_cnt_t   byteCnt_q, byteCnt_d;

   // Only the three most recent bytes need keeping; the fourth is used straight from
   // the input on the edge that writes the word.
   always_comb begin
      shift_d   = shift_q;
      byteCnt_d = byteCnt_q;
      if (byteValid_i) begin
         shift_d   = {shift_q[15:0], bootByte_i};
         byteCnt_d = bootLast_i ? 2'd0 : byteCnt_q + 2'd1;
      end
   end

   always_comb begin
      word_o     = padWord(shift_q, bootByte_i, byteCnt_q);
      wordWe_o   = byteValid_i && ((byteCnt_q == 2'd3) || bootLast_i);
      lastSeen_o = byteValid_i && bootLast_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q   <= '0;
         byteCnt_q <= 2'd0;
      end else begin
         shift_q   <= shift_d;
         byteCnt_q <= byteCnt_d;
      end
   end

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction ROM responder: loads its word array from a byte-serial boot stream while
// holding the core, then answers zero-latency instruction fetches.
module inst_rom_resp
   import inst_rom_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int DATA_W     = INST_BUS_W,
   parameter int ADDR_W     = INST_ADDR_BUS_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [ADDR_W-1:0]     addr,
   output logic [DATA_W-1:0]     inst,
   input  logic                  boot_valid,
   input  logic [BYTE_W-1:0]     boot_byte,
   input  logic                  boot_last,
   output logic                  boot_ready,
   output logic                  cpu_hold,
   output logic [DEPTH_LOG2:0]   load_words
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   boot_state_e state_q, state_d;

   logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
   logic [DEPTH_LOG2:0]   loadWords_q, loadWords_d;
   logic                  bootReady_q;
   logic                  cpuHold_q;

   logic                  byteAccept;
   logic [DATA_W-1:0]     asmWord;
   logic                  asmWe;
   logic                  asmLast;

   logic [DATA_W-1:0]     mem [DEPTH];

   // A byte arriving in the reset cycle is dropped; reset always wins.
   assign byteAccept = boot_valid && (state_q == BOOT_LOAD) && !rst;

   inst_rom_resp_boot_word_asm u_boot_word_asm (
      .clk         (clk),
      .rst         (rst),
      .byteValid_i (byteAccept),
      .bootByte_i  (boot_byte),
      .bootLast_i  (boot_last),
      .word_o      (asmWord),
      .wordWe_o    (asmWe),
      .lastSeen_o  (asmLast)
   );

   // Loading ends on the image's last byte or when the top word of the array is filled,
   // whichever comes first; nothing but reset leaves RUN.
   always_comb begin
      state_d     = state_q;
      wrPtr_d     = wrPtr_q;
      loadWords_d = loadWords_q;
      if (asmWe) begin
         wrPtr_d     = wrPtr_q + 1'b1;
         loadWords_d = loadWords_q + 1'b1;
         if (asmLast || (&wrPtr_q)) begin
            state_d = BOOT_RUN;
         end
      end
   end

   // The handshake and hold outputs follow the registered state, so they drop one
   // cycle after the final word is written.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BOOT_LOAD;
         wrPtr_q     <= '0;
         loadWords_q <= '0;
         bootReady_q <= 1'b1;
         cpuHold_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         wrPtr_q     <= wrPtr_d;
         loadWords_q <= loadWords_d;
         bootReady_q <= (state_q == BOOT_LOAD);
         cpuHold_q   <= (state_q == BOOT_LOAD);
      end
   end

   // Array contents survive reset so a reload only replaces the words it reaches.
   always_ff @(posedge clk) begin
      if (asmWe) begin
         mem[wrPtr_q] <= asmWord;
      end
   end

   logic [DEPTH_LOG2-1:0] rdIdx;
   logic                  rdInRange;
   logic                  unusedAddrLowBits;

   assign rdIdx             = addr[DEPTH_LOG2+1:2];
   assign rdInRange         = (addr[ADDR_W-1:DEPTH_LOG2+2] == '0);
   assign unusedAddrLowBits = ^addr[1:0];

   // Fetches are word aligned and combinational so the core captures pc and data together.
   always_comb begin
      inst = ZERO_WORD;
      if ((state_q == BOOT_RUN) && (ce == CHIP_ENABLE) && rdInRange) begin
         inst = mem[rdIdx];
      end
   end

   assign boot_ready = bootReady_q;
   assign cpu_hold   = cpuHold_q;
   assign load_words = loadWords_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed self-checking bench for inst_rom_resp: boot loads, padding, fetch range and
// enable gating, array-full stop and mid-load reset.
module tb_inst_rom_resp;

   localparam int DEPTH_LOG2 = 10;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   logic                  clk;
   logic                  rst;
   logic                  ce;
   logic [31:0]           addr;
   logic [31:0]           inst;
   logic                  boot_valid;
   logic [7:0]            boot_byte;
   logic                  boot_last;
   logic                  boot_ready;
   logic                  cpu_hold;
   logic [DEPTH_LOG2:0]   load_words;

   int vectors     = 0;
   int miscompares = 0;

   inst_rom_resp #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (32),
      .ADDR_W     (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .addr       (addr),
      .inst       (inst),
      .boot_valid (boot_valid),
      .boot_byte  (boot_byte),
      .boot_last  (boot_last),
      .boot_ready (boot_ready),
      .cpu_hold   (cpu_hold),
      .load_words (load_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one byte for a single rising edge, then leave the bus idle for a cycle.
   task automatic applyStimulus(input logic [7:0] b, input logic last);
      @(negedge clk);
      boot_valid = 1'b1;
      boot_byte  = b;
      boot_last  = last;
      @(negedge clk);
      boot_valid = 1'b0;
      boot_last  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
      end
   endtask

   task automatic pulseReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      ce   = 1'b1;
      addr = a;
      #1;
   endtask

   function automatic logic [7:0] fullByte(input logic [15:0] w, input int k);
      logic [7:0] b;
      case (k)
         0:       b = 8'hA5;
         1:       b = w[15:8];
         2:       b = w[7:0];
         default: b = ~w[7:0];
      endcase
      return b;
   endfunction

   initial begin
      rst        = 1'b1;
      ce         = 1'b0;
      addr       = '0;
      boot_valid = 1'b0;
      boot_byte  = '0;
      boot_last  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      fetch(32'h0);
      checkOutput("reset_cpu_hold", 32'(cpu_hold), 32'h1);
      checkOutput("reset_boot_ready", 32'(boot_ready), 32'h1);
      checkOutput("reset_load_words", 32'(load_words), 32'h0);
      checkOutput("reset_inst_zero", inst, 32'h0);

      // Single word image, last on the fourth byte; hold drops a cycle later
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h01, 1'b1);
      checkOutput("t1_load_words", 32'(load_words), 32'h1);
      checkOutput("t1_hold_lag", 32'(cpu_hold), 32'h1);
      @(negedge clk);
      checkOutput("t1_hold_released", 32'(cpu_hold), 32'h0);
      checkOutput("t1_ready_dropped", 32'(boot_ready), 32'h0);
      fetch(32'h0);
      checkOutput("t1_fetch0", inst, 32'h00000001);

      // Two-word image, low address bits ignored
      pulseReset();
      applyStimulus(8'h34, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h10, 1'b0);
      applyStimulus(8'h34, 1'b0);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h20, 1'b1);
      @(negedge clk);
      checkOutput("t2_load_words", 32'(load_words), 32'h2);
      fetch(32'h0);
      checkOutput("t2_fetch0", inst, 32'h34010010);
      fetch(32'h4);
      checkOutput("t2_fetch4", inst, 32'h34020020);
      fetch(32'h6);
      checkOutput("t2_fetch6", inst, 32'h34020020);

      // Partial tail of two bytes after three full words
      pulseReset();
      fetch(32'h0);
      checkOutput("t4_load_fetch_zero", inst, 32'h0);
      for (int i = 1; i <= 12; i++) applyStimulus(8'(i), 1'b0);
      applyStimulus(8'hAA, 1'b0);
      applyStimulus(8'hBB, 1'b1);
      @(negedge clk);
      checkOutput("t3_load_words", 32'(load_words), 32'h4);
      fetch(32'h8);
      checkOutput("t3_fetch8", inst, 32'h090A0B0C);
      fetch(32'hC);
      checkOutput("t3_tail_fetchC", inst, 32'hAABB0000);

      // Range and enable gating in RUN
      fetch(32'h0000_1000);
      checkOutput("t4_out_of_range", inst, 32'h0);
      fetch(32'h8000_0000);
      checkOutput("t4_high_bit_range", inst, 32'h0);
      ce   = 1'b0;
      addr = 32'h0;
      #1;
      checkOutput("t4_ce_low", inst, 32'h0);

      // Three-byte tail as the whole image
      pulseReset();
      applyStimulus(8'hCC, 1'b0);
      applyStimulus(8'hDD, 1'b0);
      applyStimulus(8'hEE, 1'b1);
      @(negedge clk);
      checkOutput("t3b_load_words", 32'(load_words), 32'h1);
      fetch(32'h0);
      checkOutput("t3b_tail3", inst, 32'hCCDDEE00);

      // Fill the whole array without a last marker
      pulseReset();
      for (int w = 0; w < DEPTH; w++) begin
         for (int k = 0; k < 4; k++) applyStimulus(fullByte(16'(w), k), 1'b0);
      end
      checkOutput("t5_load_words", 32'(load_words), 32'(DEPTH));
      @(negedge clk);
      checkOutput("t5_ready_low", 32'(boot_ready), 32'h0);
      checkOutput("t5_hold_low", 32'(cpu_hold), 32'h0);
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h33, 1'b0);
      applyStimulus(8'h44, 1'b1);
      checkOutput("t5_words_after_extra", 32'(load_words), 32'(DEPTH));
      fetch(32'h0);
      checkOutput("t5_mem0_kept", inst, 32'hA50000FF);
      fetch(32'hFFC);
      checkOutput("t5_top_word", inst, 32'hA503FF00);

      // Reset mid-load with a byte presented during reset, then a short reload
      pulseReset();
      applyStimulus(8'h55, 1'b0);
      applyStimulus(8'h66, 1'b0);
      applyStimulus(8'h77, 1'b0);
      applyStimulus(8'h88, 1'b0);
      applyStimulus(8'h99, 1'b0);
      applyStimulus(8'hAA, 1'b0);
      checkOutput("t6_words_before_rst", 32'(load_words), 32'h1);
      @(negedge clk);
      rst        = 1'b1;
      boot_valid = 1'b1;
      boot_byte  = 8'hEE;
      @(negedge clk);
      rst        = 1'b0;
      boot_valid = 1'b0;
      checkOutput("t6_words_cleared", 32'(load_words), 32'h0);
      checkOutput("t6_hold_again", 32'(cpu_hold), 32'h1);
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h33, 1'b0);
      applyStimulus(8'h44, 1'b1);
      @(negedge clk);
      checkOutput("t6_reload_words", 32'(load_words), 32'h1);
      fetch(32'h0);
      checkOutput("t6_reload_mem0", inst, 32'h11223344);
      fetch(32'h4);
      checkOutput("t6_mem1_stale", inst, 32'hA50001FE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
